// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: scan FSM states, the key event record
// and the event storage depth used when the FIFO build option is enabled.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_DRIVE   = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_EVAL    = 2'd2
    } scan_state_e;

    localparam int FIFO_DEPTH = 4;

    // Wide enough for the largest supported 8x8 matrix.
    localparam int MAX_CODE_W = 6;

    typedef struct packed {
        logic [MAX_CODE_W-1:0] code;
        logic                  press;
    } key_event_t;

endpackage

// File: rtl/keypad_event_fifo.sv
// Small event queue between the scanner and the consumer. A push is accepted
// while not full, or when full and a pop happens on the same edge.
module keypad_event_fifo
    import keypad_pkg::*;
#(
    parameter int Depth = FIFO_DEPTH
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       push_valid,
    output logic       push_ready,
    input  key_event_t push_data,
    output logic       pop_valid,
    input  logic       pop_ready,
    output key_event_t pop_data
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    key_event_t      mem [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] count;
    logic            do_push;
    logic            do_pop;

    // Valid/ready: a transfer happens on a posedge where valid && ready; data
    // stays stable while valid is high and ready is low.
    assign pop_valid  = (count != '0);
    assign pop_data   = mem[rd_ptr];
    assign push_ready = (count != CntW'(Depth)) || pop_ready;
    assign do_push    = push_valid && push_ready;
    assign do_pop     = pop_valid && pop_ready;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + PtrW'(1);
            end
            count <= count + CntW'(do_push) - CntW'(do_pop);
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// Row-scanning keypad matrix reader with per-key debounce and an event queue.
// Define KEYPAD_SCAN_FIFO_EN for a 4-entry event FIFO; otherwise a single register.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int Rows            = 4,
    parameter int Cols            = 4,
    parameter int ClockPeriod_ns  = 20,
    parameter int SettlePeriod_ns = 60,
    parameter int Stable          = 4
) (
    input  logic                          Clock,
    input  logic                          Reset,
    output logic [Rows-1:0]               RowDrive,
    input  logic [Cols-1:0]               ColSense,
    output logic                          EventValid,
    input  logic                          EventReady,
    output logic [$clog2(Rows*Cols)-1:0]  EventCode,
    output logic                          EventPress,
    output logic [Rows*Cols-1:0]          KeyState,
    output scan_state_e                   DebugState
);

    localparam int Keys         = Rows * Cols;
    localparam int CodeW        = $clog2(Keys);
    localparam int SettleRaw    = SettlePeriod_ns / ClockPeriod_ns;
    localparam int SettleCycles = (SettleRaw > 3) ? SettleRaw : 3;
    localparam int SetW         = $clog2(SettleCycles);
    localparam int RowW         = $clog2(Rows);
    localparam int ColW         = $clog2(Cols);
`ifdef KEYPAD_SCAN_FIFO_EN
    localparam int EventDepth   = FIFO_DEPTH;
`else
    localparam int EventDepth   = 1;
`endif

    scan_state_e       state;
    scan_state_e       state_next;
    logic [RowW-1:0]   row_idx;
    logic [RowW-1:0]   row_next;
    logic [ColW-1:0]   col_idx;
    logic [SetW-1:0]   settle_cnt;
    logic [Cols-1:0]   col_meta;
    logic [Cols-1:0]   col_sync;
    logic [Cols-1:0]   captured;
    logic [Stable-1:0] hist [Keys];
    logic [Stable-1:0] hist_new;
    logic [CodeW-1:0]  key_idx;
    logic              settle_done;
    logic              last_col;
    logic              toggle;
    logic              stall;
    logic              push_valid;
    logic              push_ready;
    key_event_t        push_evt;
    key_event_t        pop_evt;
    logic              unused_code_bits;

    assign key_idx     = CodeW'(row_idx) * CodeW'(Cols) + CodeW'(col_idx);
    assign settle_done = (settle_cnt == SetW'(SettleCycles - 1));
    assign last_col    = (col_idx == ColW'(Cols - 1));

    // A toggle that cannot be queued freezes the whole scan in place.
    always_comb begin
        hist_new = {hist[key_idx][Stable-2:0], captured[col_idx]};
        toggle   = (state == ST_EVAL) &&
                   ((&hist_new && !KeyState[key_idx]) || (~|hist_new && KeyState[key_idx]));
        stall    = toggle && !push_ready;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= ST_DRIVE;
            row_idx  <= '0;
            RowDrive <= '1;
        end else begin
            state   <= state_next;
            row_idx <= row_next;
            if (state_next == ST_DRIVE) begin
                RowDrive <= ~({{(Rows-1){1'b0}}, 1'b1} << row_next);
            end
        end
    end

    always_comb begin
        state_next = state;
        row_next   = row_idx;
        unique case (state)
            ST_DRIVE:   if (settle_done) state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = ST_EVAL;
            ST_EVAL: begin
                if (!stall && last_col) begin
                    state_next = ST_DRIVE;
                    row_next   = (row_idx == RowW'(Rows - 1)) ? '0 : row_idx + RowW'(1);
                end
            end
            default:    state_next = ST_DRIVE;
        endcase
    end

    always_comb begin
        push_valid     = toggle;
        push_evt.code  = MAX_CODE_W'(key_idx);
        push_evt.press = ~KeyState[key_idx];
        DebugState     = state;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            col_meta   <= '1;
            col_sync   <= '1;
            captured   <= '0;
            settle_cnt <= '0;
            col_idx    <= '0;
            KeyState   <= '0;
            for (int k = 0; k < Keys; k++) begin
                hist[k] <= '0;
            end
        end else begin
            col_meta <= ColSense;
            col_sync <= col_meta;
            unique case (state)
                ST_DRIVE: settle_cnt <= settle_done ? '0 : settle_cnt + SetW'(1);
                ST_CAPTURE: begin
                    captured <= ~col_sync;
                    col_idx  <= '0;
                end
                ST_EVAL: begin
                    if (!stall) begin
                        hist[key_idx] <= hist_new;
                        if (toggle) KeyState[key_idx] <= ~KeyState[key_idx];
                        col_idx <= last_col ? '0 : col_idx + ColW'(1);
                        if (last_col) settle_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    keypad_event_fifo #(
        .Depth (EventDepth)
    ) u_event_fifo (
        .Clock      (Clock),
        .Reset      (Reset),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_data  (push_evt),
        .pop_valid  (EventValid),
        .pop_ready  (EventReady),
        .pop_data   (pop_evt)
    );

    assign EventCode        = pop_evt.code[CodeW-1:0];
    assign EventPress       = pop_evt.press;
    assign unused_code_bits = ^pop_evt.code;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a 4x4 key matrix model on RowDrive/ColSense.
module tb_keypad_scan;
    import keypad_pkg::*;

`ifdef KEYPAD_SCAN_FIFO_EN
    localparam logic [3:0]  STALL_ROW  = 4'b1101;
    localparam logic [15:0] STALL_KEYS = 16'h000F;
`else
    localparam logic [3:0]  STALL_ROW  = 4'b1110;
    localparam logic [15:0] STALL_KEYS = 16'h0001;
`endif

    logic        Clock = 1'b0;
    logic        Reset;
    logic [3:0]  RowDrive;
    logic [3:0]  ColSense;
    logic        EventValid;
    logic        EventReady;
    logic [3:0]  EventCode;
    logic        EventPress;
    logic [15:0] KeyState;
    scan_state_e debug_state;

    logic [15:0] closed = '0;
    logic [4:0]  exp_q[$];
    logic [4:0]  obs_q[$];
    int          checks = 0;
    int          passed = 0;

    always #10 Clock = ~Clock;

    keypad_scan dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .RowDrive   (RowDrive),
        .ColSense   (ColSense),
        .EventValid (EventValid),
        .EventReady (EventReady),
        .EventCode  (EventCode),
        .EventPress (EventPress),
        .KeyState   (KeyState),
        .DebugState (debug_state)
    );

    // Matrix model: a closed key pulls its column low while its row is driven.
    always_comb begin
        ColSense = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!RowDrive[r] && closed[r*4+c]) ColSense[c] = 1'b0;
    end

    always @(negedge Clock) begin
        if (!Reset && EventValid && EventReady) obs_q.push_back({EventCode, EventPress});
    end

    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    // Leaves the current row-r drive (if any) and waits for the next entry into it.
    task automatic wait_row(input int r);
        logic [3:0] tgt;
        int n;
        tgt = ~(4'b0001 << r);
        n = 0;
        while (RowDrive == tgt && n < 300) begin step(1); n++; end
        while (RowDrive != tgt && n < 300) begin step(1); n++; end
        checks++;
        if (n >= 300) $display("FAIL wait_row%0d: timeout, RowDrive=%b", r, RowDrive);
        else passed++;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        EventReady = 1'b0;
        step(5);
        checks++; if (RowDrive !== 4'b1111) $display("FAIL reset_rowdrive: got %b want 1111", RowDrive); else passed++;
        checks++; if (EventValid !== 1'b0) $display("FAIL reset_valid: got %b want 0", EventValid); else passed++;
        checks++; if (KeyState !== 16'h0) $display("FAIL reset_keystate: got %h want 0000", KeyState); else passed++;
        checks++; if ({EventCode, EventPress} !== 5'b0) $display("FAIL reset_event: got %h/%b want 0/0", EventCode, EventPress); else passed++;
        checks++; if (debug_state !== ST_DRIVE) $display("FAIL reset_state: got %0d want %0d", debug_state, ST_DRIVE); else passed++;
        Reset = 1'b0;
        step(1);
        checks++; if (RowDrive !== 4'b1110) $display("FAIL rot_row0: got %b want 1110", RowDrive); else passed++;
        step(7);
        checks++; if (RowDrive !== 4'b1101) $display("FAIL rot_row1: got %b want 1101", RowDrive); else passed++;
        step(8);
        checks++; if (RowDrive !== 4'b1011) $display("FAIL rot_row2: got %b want 1011", RowDrive); else passed++;
        step(8);
        checks++; if (RowDrive !== 4'b0111) $display("FAIL rot_row3: got %b want 0111", RowDrive); else passed++;
        step(8);
        checks++; if (RowDrive !== 4'b1110) $display("FAIL rot_wrap: got %b want 1110", RowDrive); else passed++;
    endtask

    task automatic test_press_release();
        EventReady = 1'b1;
        obs_q.delete();
        wait_row(0);
        closed[5] = 1'b1;
        for (int s = 1; s <= 4; s++) begin
            wait_row(2);
            if (s == 3) begin
                checks++; if (KeyState !== 16'h0000) $display("FAIL press_early: KeyState %h want 0000", KeyState); else passed++;
                checks++; if (obs_q.size() != 0) $display("FAIL press_early_evt: %0d events want 0", obs_q.size()); else passed++;
            end
        end
        exp_q.delete();
        exp_q.push_back({4'd5, 1'b1});
        checks++; if (KeyState !== 16'h0020) $display("FAIL press_state: KeyState %h want 0020", KeyState); else passed++;
        checks++; if (obs_q.size() != 1) $display("FAIL press_count: %0d events want 1", obs_q.size()); else passed++;
        checks++; if (obs_q[0] !== exp_q[0]) $display("FAIL press_event: got %h want %h", obs_q[0], exp_q[0]); else passed++;
        obs_q.delete();
        closed[5] = 1'b0;
        for (int s = 1; s <= 4; s++) begin
            wait_row(2);
            if (s == 3) begin
                checks++; if (KeyState !== 16'h0020) $display("FAIL release_early: KeyState %h want 0020", KeyState); else passed++;
            end
        end
        exp_q.delete();
        exp_q.push_back({4'd5, 1'b0});
        checks++; if (KeyState !== 16'h0000) $display("FAIL release_state: KeyState %h want 0000", KeyState); else passed++;
        checks++; if (obs_q.size() != 1) $display("FAIL release_count: %0d events want 1", obs_q.size()); else passed++;
        checks++; if (obs_q[0] !== exp_q[0]) $display("FAIL release_event: got %h want %h", obs_q[0], exp_q[0]); else passed++;
    endtask

    task automatic test_bounce();
        obs_q.delete();
        closed[5] = 1'b1;
        for (int s = 0; s < 20; s++) begin
            wait_row(2);
            closed[5] = ~closed[5];
        end
        closed[5] = 1'b0;
        checks++; if (obs_q.size() != 0) $display("FAIL bounce_events: %0d events want 0", obs_q.size()); else passed++;
        checks++; if (KeyState !== 16'h0000) $display("FAIL bounce_state: KeyState %h want 0000", KeyState); else passed++;
    endtask

    task automatic test_stall_drain();
        int n;
        EventReady = 1'b0;
        obs_q.delete();
        wait_row(0);
        closed = 16'h003F;
        step(150);
        checks++; if (EventValid !== 1'b1) $display("FAIL stall_valid: got %b want 1", EventValid); else passed++;
        checks++; if ({EventCode, EventPress} !== {4'd0, 1'b1}) $display("FAIL stall_head: got %h/%b want 0/1", EventCode, EventPress); else passed++;
        checks++; if (RowDrive !== STALL_ROW) $display("FAIL stall_row: got %b want %b", RowDrive, STALL_ROW); else passed++;
        checks++; if (KeyState !== STALL_KEYS) $display("FAIL stall_keys: got %h want %h", KeyState, STALL_KEYS); else passed++;
        checks++; if (debug_state !== ST_EVAL) $display("FAIL stall_state: got %0d want %0d", debug_state, ST_EVAL); else passed++;
        step(10);
        checks++; if (RowDrive !== STALL_ROW) $display("FAIL stall_row_hold: got %b want %b", RowDrive, STALL_ROW); else passed++;
        checks++; if (EventCode !== 4'd0) $display("FAIL stall_code_hold: got %h want 0", EventCode); else passed++;
        exp_q.delete();
        for (int k = 0; k < 6; k++) exp_q.push_back({4'(k), 1'b1});
        EventReady = 1'b1;
        n = 0;
        while (obs_q.size() < 6 && n < 100) begin step(1); n++; end
        step(40);
        checks++; if (obs_q.size() != 6) $display("FAIL drain_count: %0d events want 6", obs_q.size()); else passed++;
        for (int k = 0; k < 6 && k < obs_q.size(); k++) begin
            checks++; if (obs_q[k] !== exp_q[k]) $display("FAIL drain_order%0d: got %h want %h", k, obs_q[k], exp_q[k]); else passed++;
        end
        checks++; if (KeyState !== 16'h003F) $display("FAIL drain_keys: got %h want 003f", KeyState); else passed++;
        wait_row(2);
    endtask

    task automatic test_reset_mid_stall();
        Reset = 1'b1;
        step(2);
        Reset = 1'b0;
        EventReady = 1'b0;
        obs_q.delete();
        closed = 16'h003F;
        step(150);
        checks++; if (EventValid !== 1'b1) $display("FAIL rst_stall_pre: valid %b want 1", EventValid); else passed++;
        Reset = 1'b1;
        step(1);
        checks++; if (EventValid !== 1'b0) $display("FAIL rst_stall_valid: got %b want 0", EventValid); else passed++;
        checks++; if (KeyState !== 16'h0) $display("FAIL rst_stall_keys: got %h want 0000", KeyState); else passed++;
        checks++; if (RowDrive !== 4'b1111) $display("FAIL rst_stall_row: got %b want 1111", RowDrive); else passed++;
        checks++; if (debug_state !== ST_DRIVE) $display("FAIL rst_stall_state: got %0d want %0d", debug_state, ST_DRIVE); else passed++;
        closed = '0;
        EventReady = 1'b1;
        step(1);
        Reset = 1'b0;
        step(200);
        checks++; if (obs_q.size() != 0) $display("FAIL rst_stale_events: %0d events want 0", obs_q.size()); else passed++;
        checks++; if (KeyState !== 16'h0) $display("FAIL rst_after_keys: got %h want 0000", KeyState); else passed++;
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_bounce();
        test_stall_drain();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter Rows, 4, number of matrix rows driven (2..8).
REQ-002 Parameter Cols, 4, number of matrix columns sensed (2..8).
REQ-003 Parameter ClockPeriod_ns, 20, Clock period in ns.
REQ-004 Parameter SettlePeriod_ns, 60, row-drive settle time before column capture; SettleCycles = max(3, SettlePeriod_ns/ClockPeriod_ns).
REQ-005 Parameter Stable, 4, consecutive agreeing scans required to change a key state (2..8).
REQ-006 Clock  input  1  single clock; all logic on posedge Clock.
REQ-007 Reset  input  1  synchronous, active-high reset.
REQ-008 RowDrive  output  Rows  row select, active-low, exactly one bit low outside reset.
REQ-009 ColSense  input  Cols  raw asynchronous column inputs, active-low (0 = key closed on driven row).
REQ-010 EventValid  output  1  key event available.
REQ-011 EventReady  input  1  consumer accepts event when EventValid && EventReady at posedge.
REQ-012 EventCode  output  $clog2(Rows*Cols)  key index = row*Cols + col.
REQ-013 EventPress  output  1  1 = press, 0 = release.
REQ-014 KeyState  output  Rows*Cols  debounced state per key, 1 = pressed.

Function
REQ-015 ColSense SHALL pass through a 2-flop synchroniser before use.
REQ-016 FSM states SHALL be DRIVE, CAPTURE, EVAL; scan row index r and column index c.
REQ-017 DRIVE: RowDrive[r] low, settle counter runs; after SettleCycles cycles -> CAPTURE.
REQ-018 CAPTURE: one cycle; inverted synchronised columns latched into a capture register; c cleared -> EVAL.
REQ-019 EVAL: one key (r,c) per cycle; history for key shifts in the captured bit, newest in LSB, Stable bits deep.
REQ-020 Key toggles when the updated history is all-ones with KeyState 0 (press) or all-zeros with KeyState 1 (release); KeyState updates and an event {code, press} is pushed the same cycle.
REQ-021 If a toggle is due and event storage is full, EVAL SHALL stall: history, KeyState, c held unchanged until space exists; no event ever lost or duplicated.
REQ-022 After c = Cols-1 is processed: r increments, wraps Rows-1 -> 0, -> DRIVE with settle counter cleared.
REQ-023 RowDrive SHALL change only on entry to DRIVE; held constant through CAPTURE/EVAL and any stall.
REQ-024 Events SHALL be delivered in generation order (row-major within scan); EventCode/EventPress stable while EventValid && !EventReady.
REQ-025 Push and pop in same cycle on full storage SHALL be allowed (no stall that cycle).

Reset
REQ-026 During Reset: RowDrive = all ones, KeyState = 0, all histories = 0, storage empty, EventValid = 0, EventCode = 0, EventPress = 0, r = 0, state DRIVE, settle counter 0.
REQ-027 First cycle after Reset deasserts: RowDrive[0] low.
REQ-028 Reset asserted mid-stall or mid-scan SHALL discard pending events and return to REQ-026 values on the next edge.

Configuration
REQ-029 KEYPAD_SCAN_FIFO_EN defined: event storage is a 4-entry FIFO.
REQ-030 KEYPAD_SCAN_FIFO_EN undefined: storage is a single-entry register (full whenever EventValid); all other behaviour identical.

Structure
REQ-031 Package keypad_pkg SHALL hold the FSM state enum, the event struct {code, press}, and the FIFO depth constant (4).
REQ-032 Event storage SHALL be sub-module keypad_event_fifo (depth parameter, valid/ready both sides); keypad_scan contains FSM, synchroniser, histories.

Verification (Rows=Cols=4, SettleCycles=3, Stable=4)
REQ-033 Reset held 5 cycles -> RowDrive=4'b1111, EventValid=0; release -> RowDrive=4'b1110 next cycle, rotates 1101, 1011, 0111, 1110.
REQ-034 Key 5 (r1,c1) closed continuously, EventReady=1 -> exactly one event code 5 press 1 after 4th row-1 scan, KeyState[5]=1; open -> one event code 5 press 0 after 4 scans.
REQ-035 Key 5 alternating closed/open every scan for 20 scans -> no events, KeyState=0.
REQ-036 Keys 0,1,2,3,4,5 closed, EventReady=0 -> (FIFO_EN) 4 events held, EVAL stalls on key 4, RowDrive frozen at 1101; EventReady=1 -> codes 0,1,2,3,4,5 in order, scan resumes.
REQ-037 Same as REQ-036 without KEYPAD_SCAN_FIFO_EN -> stall on key 1, RowDrive frozen at 1110; drains 0..5 in order.
REQ-038 Reset pulse during REQ-036 stall -> EventValid=0 next cycle, KeyState=0, no stale events after release.
